// File: rtl/ras_ptr_ctrl.sv
// ras_ptr_ctrl
//   Pointer-based controller for the return address stack (RAS).
//
//   Predicted calls and returns from the predict stage move a speculative
//   top-of-stack pointer and occupancy count. Each accepted op saves its
//   pre-op {tos, count} state in a checkpoint FIFO. EX resolves the ops in
//   order:
//     - A correct prediction retires the oldest checkpoint.
//     - A misprediction restores the oldest checkpoint, replays the actual
//       op, flushes the FIFO, and spends one cycle in RECOVER.
//
//   Optional feature (macro RAS_STAT_EN): adds 32-bit wrapping counters
//   stat_push, stat_pop and stat_recover.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   pdc_valid/is_call/is_ret   predict-stage op
//   pdc_ret_pc                 return address pushed by a predicted call
//   pdc_ready                  predict op can be accepted this cycle
//   ex_valid/is_call/is_ret    in-order resolution of the oldest op
//   ex_ret_pc, ex_mis          actual return address, mispredict flag
//   rd_ptr                     registered top-of-stack index
//   stk_empty                  stack occupancy is zero
//   stk_we/waddr/wdata         stack RAM write port (combinational)
//   ex_orphan                  EX resolution arrived with no checkpoint
//   stat_push/pop/recover      statistics counters (RAS_STAT_EN only)
module ras_ptr_ctrl #(
    parameter int STACK_LEN  = 16,
    parameter int PTR_WIDTH  = 4,
    parameter int CKPT_DEPTH = 8,
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pdc_valid,
    input  logic                  pdc_is_call,
    input  logic                  pdc_is_ret,
    input  logic [ADDR_WIDTH-1:0] pdc_ret_pc,
    output logic                  pdc_ready,
    input  logic                  ex_valid,
    input  logic                  ex_is_call,
    input  logic                  ex_is_ret,
    input  logic [ADDR_WIDTH-1:0] ex_ret_pc,
    input  logic                  ex_mis,
    output logic [PTR_WIDTH-1:0]  rd_ptr,
    output logic                  stk_empty,
    output logic                  stk_we,
    output logic [PTR_WIDTH-1:0]  stk_waddr,
    output logic [ADDR_WIDTH-1:0] stk_wdata,
    output logic                  ex_orphan
`ifdef RAS_STAT_EN
    ,
    output logic [31:0]           stat_push,
    output logic [31:0]           stat_pop,
    output logic [31:0]           stat_recover
`endif
);

    localparam int CKPT_AW = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

    localparam logic [PTR_WIDTH-1:0] PTR_ZERO = PTR_WIDTH'(0);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CNT_ZERO = (PTR_WIDTH+1)'(0);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(STACK_LEN);
    localparam logic [CKPT_AW-1:0]   IDX_ZERO = CKPT_AW'(0);
    localparam logic [CKPT_AW-1:0]   IDX_ONE  = CKPT_AW'(1);
    localparam logic [CKPT_AW:0]     OCC_ZERO = (CKPT_AW+1)'(0);
    localparam logic [CKPT_AW:0]     OCC_ONE  = (CKPT_AW+1)'(1);
    localparam logic [CKPT_AW:0]     OCC_FULL = (CKPT_AW+1)'(CKPT_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PTR_WIDTH-1:0]    tos_r;
    logic [PTR_WIDTH:0]      cnt_r;
    logic [PTR_WIDTH-1:0]    ckpt_ptr_r [CKPT_DEPTH];
    logic [PTR_WIDTH:0]      ckpt_cnt_r [CKPT_DEPTH];
    logic [CKPT_AW-1:0]      ckpt_head_r;
    logic [CKPT_AW-1:0]      ckpt_tail_r;
    logic [CKPT_AW:0]        ckpt_occ_r;

    logic                    ckpt_empty_s;
    logic                    ckpt_full_s;
    logic                    recover_s;
    logic                    dequeue_s;
    logic                    accept_s;
    logic                    op_en_s;
    logic                    op_call_s;
    logic                    op_ret_s;
    logic [PTR_WIDTH-1:0]    base_ptr_s;
    logic [PTR_WIDTH:0]      base_cnt_s;
    logic [ADDR_WIDTH-1:0]   op_pc_s;
    logic [PTR_WIDTH-1:0]    tos_nxt_s;
    logic [PTR_WIDTH:0]      cnt_nxt_s;
    logic                    we_s;
    logic [PTR_WIDTH-1:0]    waddr_s;

    // Handshake and control decode.
    // All outputs are held inactive while rstn is low.
    always_comb begin
        ckpt_empty_s = (ckpt_occ_r == OCC_ZERO);
        // ckpt_full is taken before this cycle's dequeue, so a retiring
        // checkpoint does not make room for a same-cycle predict op.
        ckpt_full_s  = (ckpt_occ_r == OCC_FULL);
        recover_s    = rstn & ex_valid & ~ckpt_empty_s & ex_mis;
        dequeue_s    = rstn & ex_valid & ~ckpt_empty_s & ~ex_mis;
        pdc_ready    = rstn & (state_r == ST_RUN) & ~ckpt_full_s & ~(ex_valid & ex_mis);
        accept_s     = pdc_valid & pdc_ready & (pdc_is_call | pdc_is_ret);
        ex_orphan    = rstn & ex_valid & ckpt_empty_s;
    end

    // Select which op reaches the stack this cycle.
    // A recovery replays the EX op on the head snapshot; otherwise an
    // accepted predict op is applied to the live state.
    always_comb begin
        op_en_s    = 1'b0;
        op_call_s  = 1'b0;
        op_ret_s   = 1'b0;
        base_ptr_s = tos_r;
        base_cnt_s = cnt_r;
        op_pc_s    = pdc_ret_pc;
        if (recover_s) begin
            op_en_s    = 1'b1;
            op_call_s  = ex_is_call;
            op_ret_s   = ex_is_ret;
            base_ptr_s = ckpt_ptr_r[ckpt_head_r];
            base_cnt_s = ckpt_cnt_r[ckpt_head_r];
            op_pc_s    = ex_ret_pc;
        end else begin
            op_en_s    = accept_s;
            op_call_s  = pdc_is_call;
            op_ret_s   = pdc_is_ret;
        end
    end

    // Apply the op.
    // A push overwrites the oldest entry once the stack is full.
    // A pop on an empty stack is a no-op.
    // call&ret (pop then push) rewrites the current top in place.
    always_comb begin
        tos_nxt_s = base_ptr_s;
        cnt_nxt_s = base_cnt_s;
        we_s      = 1'b0;
        waddr_s   = PTR_ZERO;
        if (op_en_s) begin
            case ({op_call_s, op_ret_s})
                2'b10: begin
                    tos_nxt_s = base_ptr_s + PTR_ONE;
                    cnt_nxt_s = (base_cnt_s == CNT_FULL) ? base_cnt_s : base_cnt_s + CNT_ONE;
                    we_s      = 1'b1;
                    waddr_s   = base_ptr_s + PTR_ONE;
                end
                2'b01: begin
                    if (base_cnt_s != CNT_ZERO) begin
                        tos_nxt_s = base_ptr_s - PTR_ONE;
                        cnt_nxt_s = base_cnt_s - CNT_ONE;
                    end else begin
                        tos_nxt_s = base_ptr_s;
                        cnt_nxt_s = base_cnt_s;
                    end
                end
                2'b11: begin
                    we_s    = 1'b1;
                    waddr_s = base_ptr_s;
                end
                default: begin
                    tos_nxt_s = base_ptr_s;
                    cnt_nxt_s = base_cnt_s;
                end
            endcase
        end else begin
            tos_nxt_s = tos_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Drive the stack RAM write port and the read-side status outputs.
    always_comb begin
        stk_we    = we_s;
        stk_waddr = waddr_s;
        stk_wdata = op_pc_s;
        rd_ptr    = tos_r;
        stk_empty = (cnt_r == CNT_ZERO);
    end

    // Next-state logic for the recovery FSM.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (recover_s) begin
                    state_nxt_s = ST_RECOVER;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RECOVER: state_nxt_s = ST_RUN;
            default:    state_nxt_s = ST_RUN;
        endcase
    end

    // State register, speculative top-of-stack pointer and count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RUN;
            tos_r   <= PTR_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            tos_r   <= tos_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Checkpoint FIFO pointers.
    // A recovery flushes the whole FIFO, including the head it restored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ckpt_head_r <= IDX_ZERO;
            ckpt_tail_r <= IDX_ZERO;
            ckpt_occ_r  <= OCC_ZERO;
        end else if (recover_s) begin
            ckpt_head_r <= IDX_ZERO;
            ckpt_tail_r <= IDX_ZERO;
            ckpt_occ_r  <= OCC_ZERO;
        end else begin
            if (dequeue_s) begin
                ckpt_head_r <= ckpt_head_r + IDX_ONE;
            end else begin
                ckpt_head_r <= ckpt_head_r;
            end
            if (accept_s) begin
                ckpt_tail_r <= ckpt_tail_r + IDX_ONE;
            end else begin
                ckpt_tail_r <= ckpt_tail_r;
            end
            case ({accept_s, dequeue_s})
                2'b10:   ckpt_occ_r <= ckpt_occ_r + OCC_ONE;
                2'b01:   ckpt_occ_r <= ckpt_occ_r - OCC_ONE;
                default: ckpt_occ_r <= ckpt_occ_r;
            endcase
        end
    end

    // Checkpoint payload storage.
    // Validity is tracked by the pointers above, so the payload is not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            ckpt_ptr_r[ckpt_tail_r] <= tos_r;
            ckpt_cnt_r[ckpt_tail_r] <= cnt_r;
        end
    end

`ifdef RAS_STAT_EN
    // Statistics counters.
    // Pushes and pops count every op applied to the stack, including the op
    // replayed on recovery. call&ret counts once in each.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_push    <= 32'd0;
            stat_pop     <= 32'd0;
            stat_recover <= 32'd0;
        end else begin
            stat_push    <= stat_push    + {31'd0, op_en_s & op_call_s};
            stat_pop     <= stat_pop     + {31'd0, op_en_s & op_ret_s};
            stat_recover <= stat_recover + {31'd0, recover_s};
        end
    end
`endif

endmodule

// File: doc/ras_ptr_ctrl.md
Name: ras_ptr_ctrl

Overview:
Pointer-based controller for the return address stack. It sequences speculative push/pop requests from the predict stage and keeps a FIFO of pointer checkpoints, one per in-flight call/ret. It retires or repairs those checkpoints on in-order resolution from EX. It drives the stack RAM write port and the top-of-stack read pointer.

Parameters:
STACK_LEN, 16, number of stack entries (power of 2)
PTR_WIDTH, 4, log2(STACK_LEN)
CKPT_DEPTH, 8, checkpoint FIFO entries (power of 2)
ADDR_WIDTH, 30, return-address width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
pdc_valid  in  1  predict-stage op present
pdc_is_call  in  1  predicted call
pdc_is_ret  in  1  predicted return
pdc_ret_pc  in  ADDR_WIDTH  return address to push on predicted call
pdc_ready  out  1  controller accepts predict op this cycle
ex_valid  in  1  EX resolves oldest in-flight call/ret
ex_is_call  in  1  actual op is call
ex_is_ret  in  1  actual op is return
ex_ret_pc  in  ADDR_WIDTH  actual return address (call)
ex_mis  in  1  prediction for this op was wrong
rd_ptr  out  PTR_WIDTH  top-of-stack index for prediction read
stk_empty  out  1  count==0
stk_we  out  1  stack RAM write enable
stk_waddr  out  PTR_WIDTH  write index
stk_wdata  out  ADDR_WIDTH  write data
ex_orphan  out  1  pulse: ex_valid with empty checkpoint FIFO

Behaviour:
- Reset (async, rstn=0): tos_ptr=0, count=0, FIFO empty, state=RUN; pdc_ready=0 while in reset; stk_we=0, ex_orphan=0; rd_ptr=0; stk_empty=1. A reset mid-recovery or mid-stream discards everything.
- FSM: RUN, RECOVER. RUN->RECOVER on ex_valid&ex_mis&FIFO non-empty. RECOVER->RUN unconditionally after 1 cycle.
- pdc_ready = (state==RUN) & ~ckpt_full & ~(ex_valid&ex_mis). Accept = pdc_valid&pdc_ready&(pdc_is_call|pdc_is_ret). Ops with neither flag are ignored and not enqueued.
- On accept, enqueue {tos_ptr,count} as it stands before the op, then apply the op:
  - call only: tos_ptr+1 (mod STACK_LEN); count=min(count+1,STACK_LEN); stk_we=1, waddr=tos_ptr+1, wdata=pdc_ret_pc. When full, the oldest entry is overwritten.
  - ret only: if count>0, tos_ptr-1 (mod) and count-1. If count==0, pointer and count are unchanged; stk_empty remains 1.
  - call&ret: treated as pop-then-push. Pointer and count are unchanged; stk_we=1 at waddr=tos_ptr.
- ex_valid, FIFO non-empty, ~ex_mis: dequeue head only. Stack state is unchanged.
- ex_valid, FIFO non-empty, ex_mis:
  - Restore tos_ptr/count from the head snapshot, then apply the actual op (same rules as above, using ex_is_call/ex_is_ret/ex_ret_pc). stk_we is driven by the EX op.
  - Flush the whole FIFO and drop any same-cycle predict op.
- ex_valid with FIFO empty: ignored; ex_orphan=1 for that cycle.
- Simultaneous non-mispredicting ex dequeue and pdc enqueue: both happen; occupancy is unchanged. ckpt_full is evaluated before the dequeue, with no bypass.
- stk_we/waddr/wdata are combinational from the current cycle's accepted op; the RAM writes at the clock edge. rd_ptr = registered tos_ptr, so the new top is visible the cycle after the op.
- Write-port priority: EX recovery write; a predict write cannot coincide because the predict op is blocked.
- Width rules: pointer arithmetic wraps modulo 2^PTR_WIDTH. count is PTR_WIDTH+1 bits and saturates at 0 and STACK_LEN.

Optional Feature:
RAS_STAT_EN: adds outputs stat_push, stat_pop, stat_recover (32-bit each, reset 0, wrap on overflow), counting accepted pushes, accepted pops, and recoveries. Call&ret counts once in each of stat_push and stat_pop. Without the macro, these ports and counters do not exist.

Test Plan:
- Reset, 3 accepted calls with pc 0x10,0x20,0x30 -> rd_ptr=3, writes at idx 1,2,3, count=3, FIFO occupancy 3.
- 17 calls without resolution, CKPT_DEPTH=8 -> pdc_ready drops after 8th accept. Then 8 correct ex resolves -> ready returns, rd_ptr=8.
- Ret with count=0 -> rd_ptr stays 0, stk_empty=1, checkpoint still enqueued. Matching ex resolve with ex_mis=0 -> FIFO empties, ex_orphan=0.
- Calls 0x10,0x20 then predicted ret; ex resolves call0, call1 OK, then ret with ex_mis=1 and ex_is_call=1, pc 0x44 -> tos=3, write 0x44 at idx3, FIFO empty, pdc_ready=0 one cycle.
- 17 pushes with periodic resolves -> wrap: 17th write at idx1, count saturates 16.
- rstn pulled low asynchronously while state=RECOVER -> immediately tos_ptr=0, FIFO empty, state=RUN after release.
